spi_master: RTL
===============

Name: spi_master

Overview:
- Command-level SPI master that sits directly upstream of the SPI-slave/RAM subsystem.
- Drives MOSI/SS_n and captures MISO.
- Takes a 2-bit command plus an 8-bit payload from a host-side request port and serialises it as one framed transaction.
- For read-data commands, captures the 8-bit reply and returns it to the host.
- Shares the subsystem clock; no SCK is generated.

Parameters:
- RD_LAT, 2, cycles between the last MOSI bit and the first MISO sample on a read-data frame (legal 1..15).
- MIN_IDLE, 1, cycles SS_n is held high after a frame before busy drops (legal 1..15).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request strobe; accepted only when busy=0.
- cmd  input  2  00 write addr, 01 write data, 10 read addr, 11 read data.
- din  input  8  address or write-data payload; don't-care payload for cmd=11.
- busy  output  1  high from the cycle after acceptance until the idle gap ends.
- done  output  1  one-cycle pulse in the cycle SS_n returns high.
- dout  output  8  read data; updated only on cmd=11 frames.
- dout_valid  output  1  one-cycle pulse coincident with done on cmd=11 frames.
- MOSI  output  1  serial data to slave, registered.
- SS_n  output  1  slave select, active low, registered.
- MISO  input  1  serial data from slave.

Behaviour:
- Interface decision: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: SS_n=1, MOSI=0, busy=0, done=0, dout_valid=0, dout=8'h00, state IDLE.
- FSM states: IDLE, SHIFT, RD_WAIT, RD_SHIFT, GAP.
- IDLE:
  - start=1 latches cmd/din into a 10-bit shift register {cmd, din}; go to SHIFT.
  - busy=1 from the next cycle.
  - start while busy=1 is ignored, not queued.
- SHIFT:
  - SS_n=0 for 11 cycles.
  - MOSI sequence: select bit cmd[1], then cmd[1], cmd[0], din[7]..din[0], MSB first.
  - First SHIFT cycle is cycle 1 after the start cycle (cycle 0).
  - After bit 11: cmd!=11 -> GAP; cmd=11 -> RD_WAIT.
- RD_WAIT:
  - SS_n=0, MOSI=0 for RD_LAT cycles; MISO ignored.
- RD_SHIFT:
  - SS_n=0, MOSI=0 for 8 cycles.
  - Samples MISO each rising edge, MSB first, into a capture register.
- GAP:
  - On entry, SS_n=1 and done=1 for one cycle.
  - On cmd=11 frames, dout is loaded with the captured byte and dout_valid=1 in that same cycle.
  - Stay MIN_IDLE cycles with SS_n=1, then busy=0 and return to IDLE.
- Latency, write/read-addr frames:
  - SS_n low cycles 1..11.
  - done at cycle 12.
  - busy low from cycle 12+MIN_IDLE.
- Latency, read-data frames:
  - SS_n low cycles 1..11+RD_LAT+8.
  - done/dout_valid at cycle 12+RD_LAT+8 (22 at default).
- Back-to-back: start is legal in the first cycle busy=0, so SS_n is high for at least MIN_IDLE+1 cycles between frames.
- Counters: 4-bit bit counter and 4-bit wait counter; no wrap, each cleared on state entry.
- dout holds its value across non-read frames.
- rst_n low mid-frame: all outputs return to their reset values immediately. No done pulse; the partial frame is abandoned.
- start asserted in the reset-release cycle is ignored.

Optional Feature:
- Macro: SPI_MASTER_SEQ_CHK_EN.
- Defined:
  - Adds output err (1 bit, reset 0) and a "read address pending" flag.
  - The flag is set by a completed cmd=10 frame and cleared by a completed cmd=11 frame.
  - cmd=11 accepted with the flag clear sends no frame (SS_n stays 1).
  - In that case busy=1 for one cycle, then done=1 and err=1 together for one cycle, dout unchanged, dout_valid=0.
  - err is otherwise 0.
- Undefined: no err port and no checking; every command is framed.

Test Plan:
- Reset, then start cmd=00 din=8'hA5 -> SS_n low cycles 1..11, MOSI=0,0,0,1,0,1,0,0,1,0,1, done at cycle 12, busy=0 at cycle 13.
- cmd=10 din=8'h3C, then cmd=11 with MISO driving 8'h96 MSB-first starting cycle 14 -> dout=8'h96, dout_valid and done at cycle 22, SS_n continuously low cycles 1..21.
- start held high across a write frame -> exactly one frame; second frame's SS_n falls 2 cycles after done (default MIN_IDLE).
- rst_n pulsed low at cycle 6 of a cmd=01 frame -> SS_n=1, MOSI=0, busy=0 same cycle, no done; next start produces a clean 11-bit frame.
- RD_LAT=4, MIN_IDLE=3 build -> cmd=11 done at cycle 24; busy drops at cycle 27.
- SPI_MASTER_SEQ_CHK_EN defined, cmd=11 right after reset -> SS_n never falls, err=done=1 at cycle 2, dout stays 8'h00.

Source files
------------

// File: rtl/spi_master.sv
// Command-level SPI master: frames {cmd, din} on MOSI/SS_n and captures an 8-bit reply on read-data frames.
// Optional SPI_MASTER_SEQ_CHK_EN adds an err output that rejects read-data without a preceding read-address frame.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for start; SS_n high, busy low
// SHIFT    | 11 MOSI bits: select bit, cmd[1:0], din[7:0]
// RD_WAIT  | RD_LAT turnaround cycles before the reply
// RD_SHIFT | 8 MISO samples, MSB first
// GAP      | SS_n high for MIN_IDLE cycles; done on entry
// CHK_ERR  | rejected read-data command (sequence check build only)
module spi_master #(
  parameter int unsigned RD_LAT   = 2,
  parameter int unsigned MIN_IDLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] cmd,
  input  logic [7:0] din,
  output logic       busy,
  output logic       done,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic       MOSI,
  output logic       SS_n,
`ifdef SPI_MASTER_SEQ_CHK_EN
  output logic       err,
`endif
  input  logic       MISO
);

  typedef enum logic [2:0] {IDLE, SHIFT, RD_WAIT, RD_SHIFT, GAP, CHK_ERR} state_t;

  localparam logic [3:0] RD_TC  = 4'(RD_LAT - 1);
  localparam logic [3:0] GAP_TC = 4'(MIN_IDLE - 1);

  state_t      state, state_d;
  logic [3:0]  bit_cnt, bit_cnt_d;
  logic [3:0]  wait_cnt, wait_cnt_d;
  logic [9:0]  sh, sh_d;
  logic [1:0]  cmd_q, cmd_d;
  logic [7:0]  cap, cap_d;
  logic [7:0]  dout_d;
  logic        armed;
  logic        busy_d, done_d, dv_d, mosi_d, ss_n_d;
`ifdef SPI_MASTER_SEQ_CHK_EN
  logic        pend, pend_d;
  logic        err_d;
`endif

  // armed blocks acceptance on the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      wait_cnt   <= '0;
      sh         <= '0;
      cmd_q      <= '0;
      cap        <= '0;
      dout       <= '0;
      armed      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      dout_valid <= 1'b0;
      MOSI       <= 1'b0;
      SS_n       <= 1'b1;
`ifdef SPI_MASTER_SEQ_CHK_EN
      pend       <= 1'b0;
      err        <= 1'b0;
`endif
    end else begin
      state      <= state_d;
      bit_cnt    <= bit_cnt_d;
      wait_cnt   <= wait_cnt_d;
      sh         <= sh_d;
      cmd_q      <= cmd_d;
      cap        <= cap_d;
      dout       <= dout_d;
      armed      <= 1'b1;
      busy       <= busy_d;
      done       <= done_d;
      dout_valid <= dv_d;
      MOSI       <= mosi_d;
      SS_n       <= ss_n_d;
`ifdef SPI_MASTER_SEQ_CHK_EN
      pend       <= pend_d;
      err        <= err_d;
`endif
    end
  end

  // Outputs are computed for the next cycle so every pin comes straight from a flop.
  always_comb begin
    state_d    = state;
    bit_cnt_d  = bit_cnt;
    wait_cnt_d = wait_cnt;
    sh_d       = sh;
    cmd_d      = cmd_q;
    cap_d      = cap;
    dout_d     = dout;
    mosi_d     = 1'b0;
    ss_n_d     = SS_n;
    done_d     = 1'b0;
    dv_d       = 1'b0;
`ifdef SPI_MASTER_SEQ_CHK_EN
    pend_d     = pend;
    err_d      = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start && armed) begin
          cmd_d     = cmd;
          sh_d      = {cmd, din};
          bit_cnt_d = '0;
          state_d   = SHIFT;
          ss_n_d    = 1'b0;
          mosi_d    = cmd[1];
`ifdef SPI_MASTER_SEQ_CHK_EN
          if (cmd == 2'b11 && !pend) begin
            state_d = CHK_ERR;
            ss_n_d  = 1'b1;
            mosi_d  = 1'b0;
          end
`endif
        end
      end
      SHIFT: begin
        if (bit_cnt == 4'd10) begin
          wait_cnt_d = '0;
          if (cmd_q == 2'b11) begin
            state_d = RD_WAIT;
          end else begin
            state_d = GAP;
            ss_n_d  = 1'b1;
            done_d  = 1'b1;
`ifdef SPI_MASTER_SEQ_CHK_EN
            if (cmd_q == 2'b10) pend_d = 1'b1;
`endif
          end
        end else begin
          mosi_d    = sh[9];
          sh_d      = {sh[8:0], 1'b0};
          bit_cnt_d = bit_cnt + 4'd1;
        end
      end
      RD_WAIT: begin
        if (wait_cnt == RD_TC) begin
          state_d   = RD_SHIFT;
          bit_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt + 4'd1;
        end
      end
      RD_SHIFT: begin
        cap_d = {cap[6:0], MISO};
        if (bit_cnt == 4'd7) begin
          state_d    = GAP;
          wait_cnt_d = '0;
          ss_n_d     = 1'b1;
          done_d     = 1'b1;
          dv_d       = 1'b1;
          dout_d     = {cap[6:0], MISO};
`ifdef SPI_MASTER_SEQ_CHK_EN
          pend_d     = 1'b0;
`endif
        end else begin
          bit_cnt_d = bit_cnt + 4'd1;
        end
      end
      GAP: begin
        if (wait_cnt == GAP_TC) state_d = IDLE;
        else                    wait_cnt_d = wait_cnt + 4'd1;
      end
      CHK_ERR: begin
        state_d = IDLE;
        done_d  = 1'b1;
`ifdef SPI_MASTER_SEQ_CHK_EN
        err_d   = 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

endmodule
